rvga_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-ported DDR memory model between the core's instruction-fetch port and data-memory port. Sits between the fetch/memory stages and the memory, serialising accesses so that exactly one transaction is outstanding at a time. Requests are latched, presented to memory as registered strobes, and the response is steered back to the winning requester. Tolerates any memory response latency of one or more cycles.

---
 rtl/rvga_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_rvga_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rvga_mem_arbiter.sv
// rvga_mem_arbiter: two-requester (fetch / data) arbiter in front of a
// single-ported memory. One transaction is outstanding at a time; requests are
// latched into registered mem_* strobes and the response is steered back to
// the granted port.
// Optional feature: define RVGA_MEM_ARB_RR_EN for round-robin tie-break;
// otherwise the data port has fixed priority on ties.
module rvga_mem_arbiter #(
   parameter int unsigned addr_width_p = 32,
   parameter int unsigned data_width_p = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    i_r_v_i,
   input  logic [addr_width_p-1:0] i_addr_i,
   output logic [data_width_p-1:0] i_data_o,
   output logic                    i_resp_v_o,
   input  logic                    d_r_v_i,
   input  logic                    d_w_v_i,
   input  logic [addr_width_p-1:0] d_addr_i,
   input  logic [data_width_p-1:0] d_data_i,
   output logic [data_width_p-1:0] d_data_o,
   output logic                    d_resp_v_o,
   output logic                    mem_r_v_o,
   output logic                    mem_w_v_o,
   output logic [addr_width_p-1:0] mem_addr_o,
   output logic [data_width_p-1:0] mem_data_o,
   input  logic [data_width_p-1:0] mem_data_i,
   input  logic                    mem_resp_v_i,
   output logic                    err_o
);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t                  state;
   logic                    owner_d;    // 1: data port owns the outstanding transaction
   logic [data_width_p-1:0] i_data_q;
   logic [data_width_p-1:0] d_data_q;
   logic                    i_req;
   logic                    d_req;
   logic                    grant_d;
   logic                    resp_cycle;

`ifdef RVGA_MEM_ARB_RR_EN
   logic last_d;                        // 1: data port was granted last
`endif

   // Winner selection for the current IDLE cycle
   always_comb begin
      i_req = i_r_v_i;
      d_req = d_r_v_i | d_w_v_i;
`ifdef RVGA_MEM_ARB_RR_EN
      grant_d = d_req & (~i_req | ~last_d);
`else
      grant_d = d_req;
`endif
   end

   // Response steering: strobes and read data are combinational in the response cycle
   always_comb begin
      resp_cycle = (state == BUSY) & mem_resp_v_i;
      i_resp_v_o = resp_cycle & ~owner_d;
      d_resp_v_o = resp_cycle & owner_d;
      i_data_o   = i_resp_v_o ? mem_data_i : i_data_q;
      d_data_o   = (d_resp_v_o & mem_r_v_o) ? mem_data_i : d_data_q;
   end

   // Arbitration FSM with registered memory strobes and per-port read-data holding
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         owner_d    <= 1'b0;
         mem_r_v_o  <= 1'b0;
         mem_w_v_o  <= 1'b0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
         i_data_q   <= '0;
         d_data_q   <= '0;
         err_o      <= 1'b0;
`ifdef RVGA_MEM_ARB_RR_EN
         last_d     <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_req | d_req) begin
                  state   <= BUSY;
                  owner_d <= grant_d;
`ifdef RVGA_MEM_ARB_RR_EN
                  last_d  <= grant_d;
`endif
                  if (grant_d) begin
                     // a simultaneous read+write is issued as a write and flagged
                     mem_r_v_o  <= ~d_w_v_i;
                     mem_w_v_o  <= d_w_v_i;
                     mem_addr_o <= d_addr_i;
                     mem_data_o <= d_data_i;
                     if (d_r_v_i & d_w_v_i) begin
                        err_o <= 1'b1;
                     end
                  end else begin
                     mem_r_v_o  <= 1'b1;
                     mem_w_v_o  <= 1'b0;
                     mem_addr_o <= i_addr_i;
                  end
               end
            end
            BUSY: begin
               if (mem_resp_v_i) begin
                  state     <= IDLE;
                  mem_r_v_o <= 1'b0;
                  mem_w_v_o <= 1'b0;
                  if (mem_r_v_o) begin
                     if (owner_d) begin
                        d_data_q <= mem_data_i;
                     end else begin
                        i_data_q <= mem_data_i;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Directed self-checking bench for rvga_mem_arbiter with a small memory model
// that has a programmable number of wait states.
module tb_rvga_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        i_r_v;
   logic [31:0] i_addr;
   logic [31:0] i_data;
   logic        i_resp_v;
   logic        d_r_v;
   logic        d_w_v;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_resp_v;
   logic        mem_r_v;
   logic        mem_w_v;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp_v;
   logic        err;

   logic [31:0] mem [0:255];
   int unsigned wait_states;
   int unsigned wcnt;
   logic        model_resp;
   logic        force_resp;

   int n_pass;
   int n_fail;

   rvga_mem_arbiter #(.addr_width_p(32), .data_width_p(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .i_r_v_i     (i_r_v),
      .i_addr_i    (i_addr),
      .i_data_o    (i_data),
      .i_resp_v_o  (i_resp_v),
      .d_r_v_i     (d_r_v),
      .d_w_v_i     (d_w_v),
      .d_addr_i    (d_addr),
      .d_data_i    (d_wdata),
      .d_data_o    (d_rdata),
      .d_resp_v_o  (d_resp_v),
      .mem_r_v_o   (mem_r_v),
      .mem_w_v_o   (mem_w_v),
      .mem_addr_o  (mem_addr),
      .mem_data_o  (mem_wdata),
      .mem_data_i  (mem_rdata),
      .mem_resp_v_i(mem_resp_v),
      .err_o       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign model_resp = (mem_r_v | mem_w_v) && (wcnt == wait_states);
   assign mem_resp_v = model_resp | force_resp;
   assign mem_rdata  = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 256; k++) mem[k] <= '0;
         mem[64] <= 32'h0000_0013;
         wcnt    <= 0;
      end else begin
         if ((mem_r_v | mem_w_v) && !model_resp) wcnt <= wcnt + 1;
         else wcnt <= 0;
         if (mem_w_v && mem_resp_v) mem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int got[$];
      int exp_seq[4];
      bit done;

      n_pass = 0; n_fail = 0;
      rst = 1'b1; i_r_v = 0; i_addr = '0; d_r_v = 0; d_w_v = 0;
      d_addr = '0; d_wdata = '0; wait_states = 0; force_resp = 0;

      // reset values
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_mem_r", {31'b0, mem_r_v}, 0);
      chk("rst_mem_w", {31'b0, mem_w_v}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_wdata, 0);
      chk("rst_i_resp", {31'b0, i_resp_v}, 0);
      chk("rst_d_resp", {31'b0, d_resp_v}, 0);
      chk("rst_i_data", i_data, 0);
      chk("rst_d_data", d_rdata, 0);
      chk("rst_err", {31'b0, err}, 0);

      // single fetch, zero-wait memory
      i_r_v = 1; i_addr = 32'h100;
      @(negedge clk);
      chk("f_mem_r", {31'b0, mem_r_v}, 1);
      chk("f_mem_addr", mem_addr, 32'h100);
      chk("f_i_resp", {31'b0, i_resp_v}, 1);
      chk("f_i_data", i_data, 32'h13);
      chk("f_d_resp", {31'b0, d_resp_v}, 0);
      i_r_v = 0;
      @(negedge clk);
      chk("f_idle_mem_r", {31'b0, mem_r_v}, 0);
      chk("f_idle_i_resp", {31'b0, i_resp_v}, 0);
      chk("f_i_data_hold", i_data, 32'h13);

      // data write then read
      d_w_v = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("w_mem_w", {31'b0, mem_w_v}, 1);
      chk("w_mem_r", {31'b0, mem_r_v}, 0);
      chk("w_mem_addr", mem_addr, 32'h200);
      chk("w_mem_data", mem_wdata, 32'hDEAD_BEEF);
      chk("w_d_resp", {31'b0, d_resp_v}, 1);
      chk("w_d_data_unch", d_rdata, 0);
      chk("w_i_resp", {31'b0, i_resp_v}, 0);
      d_w_v = 0; d_r_v = 1; d_wdata = '0;
      @(negedge clk);
      chk("wr_gap_mem_w", {31'b0, mem_w_v}, 0);
      chk("wr_gap_d_resp", {31'b0, d_resp_v}, 0);
      @(negedge clk);
      chk("r_mem_r", {31'b0, mem_r_v}, 1);
      chk("r_d_resp", {31'b0, d_resp_v}, 1);
      chk("r_d_data", d_rdata, 32'hDEAD_BEEF);
      chk("r_i_resp", {31'b0, i_resp_v}, 0);
      d_r_v = 0;
      @(negedge clk);
      chk("r_d_data_hold", d_rdata, 32'hDEAD_BEEF);
      chk("r_i_data_unch", i_data, 32'h13);

      // contention: both ports held for four transactions
`ifdef RVGA_MEM_ARB_RR_EN
      exp_seq = '{0, 1, 0, 1};
`else
      exp_seq = '{1, 1, 1, 1};
`endif
      i_r_v = 1; i_addr = 32'h0; d_r_v = 1; d_addr = 32'h40;
      for (int c = 0; c < 60 && got.size() < 4; c++) begin
         @(negedge clk);
         if (i_resp_v) got.push_back(0);
         if (d_resp_v) got.push_back(1);
      end
      i_r_v = 0; d_r_v = 0;
      chk("cont_count", got.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < got.size()) chk($sformatf("cont_grant%0d", k), got[k], exp_seq[k]);
      end
      @(negedge clk);

      // wait states: fetch with three extra cycles, data request raised mid-transaction
      wait_states = 3;
      i_r_v = 1; i_addr = 32'h100;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 0) begin d_r_v = 1; d_addr = 32'h200; end
         chk($sformatf("ws_mem_r%0d", c), {31'b0, mem_r_v}, 1);
         chk($sformatf("ws_addr%0d", c), mem_addr, 32'h100);
         chk($sformatf("ws_i_resp%0d", c), {31'b0, i_resp_v}, (c == 3) ? 1 : 0);
         chk($sformatf("ws_d_resp%0d", c), {31'b0, d_resp_v}, 0);
      end
      i_r_v = 0;
      @(negedge clk);
      chk("ws_idle_mem_r", {31'b0, mem_r_v}, 0);
      chk("ws_idle_d_resp", {31'b0, d_resp_v}, 0);
      @(negedge clk);
      chk("ws_d_grant_mem_r", {31'b0, mem_r_v}, 1);
      chk("ws_d_grant_addr", mem_addr, 32'h200);
      d_r_v = 0;
      done = 0;
      for (int c = 0; c < 10 && !done; c++) begin
         if (d_resp_v) begin
            done = 1;
            chk("ws_d_data", d_rdata, 32'hDEAD_BEEF);
         end else @(negedge clk);
      end
      chk("ws_d_resp_seen", {31'b0, done}, 1);
      @(negedge clk);

      // reset in the middle of a busy read
      d_r_v = 1; d_addr = 32'h80;
      @(negedge clk);
      chk("rb_mem_r", {31'b0, mem_r_v}, 1);
      rst = 1; d_r_v = 0;
      @(negedge clk);
      rst = 0;
      chk("rb_mem_r0", {31'b0, mem_r_v}, 0);
      chk("rb_mem_addr0", mem_addr, 0);
      chk("rb_i_data0", i_data, 0);
      chk("rb_d_data0", d_rdata, 0);
      force_resp = 1;
      #1;
      chk("rb_i_resp", {31'b0, i_resp_v}, 0);
      chk("rb_d_resp", {31'b0, d_resp_v}, 0);
      @(negedge clk);
      chk("rb_late_d_resp", {31'b0, d_resp_v}, 0);
      chk("rb_late_mem_r", {31'b0, mem_r_v}, 0);
      chk("rb_late_mem_w", {31'b0, mem_w_v}, 0);
      force_resp = 0;
      wait_states = 0;

      // illegal op: read and write together
      d_r_v = 1; d_w_v = 1; d_addr = 32'h10; d_wdata = 32'h5555_AAAA;
      @(negedge clk);
      chk("il_mem_w", {31'b0, mem_w_v}, 1);
      chk("il_mem_r", {31'b0, mem_r_v}, 0);
      chk("il_addr", mem_addr, 32'h10);
      chk("il_err", {31'b0, err}, 1);
      chk("il_d_data_unch", d_rdata, 0);
      d_r_v = 0; d_w_v = 0;
      repeat (3) @(negedge clk);
      chk("il_err_sticky", {31'b0, err}, 1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("il_err_cleared", {31'b0, err}, 0);

      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end

endmodule
